// File: rtl/wb_ram_burst.sv
// Wishbone B4 single-port RAM slave with registered-feedback bursts (CTI/BTE).
// Optional error response for reserved CTI codes: define WB_RAM_BURST_ERR_EN.
module wb_ram_burst #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   input  logic                    we_i,
   input  logic [SELECT_WIDTH-1:0] sel_i,
   input  logic                    stb_i,
   input  logic                    cyc_i,
   input  logic [2:0]              cti_i,
   input  logic [1:0]              bte_i,
   output logic                    ack_o,
   output logic                    err_o
);
   localparam int LSB   = $clog2(SELECT_WIDTH);
   localparam int WAW   = ADDR_WIDTH - LSB;
   localparam int DEPTH = 2 ** WAW;

   localparam logic [2:0] CTI_CONST = 3'b001;
   localparam logic [2:0] CTI_INCR  = 3'b010;

   typedef logic [WAW-1:0] waddr_t;
   typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST, S_ERR} state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   state_t                state_q;
   logic                  ack_q;
   logic [DATA_WIDTH-1:0] dat_q;
   waddr_t                cur_w, nxt_w, wrap_mask;
   logic                  beat_done, wr_en;
   logic [DATA_WIDTH-1:0] cur_merged, nxt_rd;

   assign cur_w = adr_i[ADDR_WIDTH-1:LSB];

   // Wrap bursts only advance the low log2(N) word bits; linear uses the full word.
   always_comb begin
      case (bte_i)
         2'b01:   wrap_mask = waddr_t'(3);
         2'b10:   wrap_mask = waddr_t'(7);
         2'b11:   wrap_mask = waddr_t'(15);
         default: wrap_mask = '1;
      endcase
   end
   assign nxt_w = (cur_w & ~wrap_mask) | ((cur_w + waddr_t'(1)) & wrap_mask);

   assign beat_done = cyc_i & stb_i & ack_q;
   assign wr_en     = beat_done & we_i & ~rst;

   // Current word as it will look after this beat's write (write-first view).
   always_comb begin
      cur_merged = mem[cur_w];
      for (int i = 0; i < SELECT_WIDTH; i++)
         if (we_i && sel_i[i]) cur_merged[8*i +: 8] = dat_i[8*i +: 8];
   end
   assign nxt_rd = (we_i && nxt_w == cur_w) ? cur_merged : mem[nxt_w];

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int i = 0; i < SELECT_WIDTH; i++)
            if (sel_i[i]) mem[cur_w][8*i +: 8] <= dat_i[8*i +: 8];
   end

`ifdef WB_RAM_BURST_ERR_EN
   logic err_q;
   logic cti_rsvd;
   assign cti_rsvd = (cti_i >= 3'b011) && (cti_i <= 3'b110);
   assign err_o    = err_q & cyc_i & stb_i;
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= '0;
`ifdef WB_RAM_BURST_ERR_EN
         err_q   <= 1'b0;
`endif
      end else if (!cyc_i) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
`ifdef WB_RAM_BURST_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (stb_i && !ack_q) begin
`ifdef WB_RAM_BURST_ERR_EN
                  if (cti_rsvd) begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end else begin
`else
                  begin
`endif
                     dat_q   <= mem[cur_w];
                     ack_q   <= 1'b1;
                     state_q <= (cti_i == CTI_CONST || cti_i == CTI_INCR) ? S_BURST : S_CLASSIC;
                  end
               end
            end
            S_CLASSIC: begin
               if (beat_done) begin
                  ack_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_BURST: begin
               if (beat_done) begin
                  case (cti_i)
                     CTI_INCR:  dat_q <= nxt_rd;
                     CTI_CONST: dat_q <= cur_merged;
                     default: begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                     end
                  endcase
               end
            end
            S_ERR: begin
`ifdef WB_RAM_BURST_ERR_EN
               if (stb_i && err_q) begin
                  err_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
`else
               state_q <= S_IDLE;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dat_o = dat_q;
   assign ack_o = ack_q & cyc_i & stb_i;

   if (LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^adr_i[LSB-1:0];
   end
endmodule

// File: tb/tb_wb_ram_burst.sv
// Self-checking bench for wb_ram_burst: directed table, hand-written corner
// sequences and randomized transactions against a word-array reference model.
module tb_wb_ram_burst;
   localparam int DW = 32, AW = 16, SW = 4;
   localparam int DEPTH = 1 << 14;

   logic          clk = 1'b0, rst = 1'b1;
   logic [AW-1:0] adr_i = '0;
   logic [DW-1:0] dat_i = '0, dat_o;
   logic          we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0, ack_o, err_o;
   logic [SW-1:0] sel_i = '0;
   logic [2:0]    cti_i = '0;
   logic [1:0]    bte_i = '0;

   wb_ram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
      .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i),
      .cti_i(cti_i), .bte_i(bte_i), .ack_o(ack_o), .err_o(err_o));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   logic [31:0] mdl [DEPTH];

   typedef struct {
      bit          we;
      logic [15:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // Next beat address derived from the burst rules with plain arithmetic.
   function automatic int nxt(input int w, input logic [1:0] bte);
      int n;
      if (bte == 2'b00) return (w + 1) % DEPTH;
      n = 2 << bte;
      return (w / n) * n + (w + 1) % n;
   endfunction

   task automatic mdl_write(input int w, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++)
         if (s[i]) mdl[w][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic bus_idle();
      cyc_i = 0; stb_i = 0; we_i = 0; cti_i = 0; bte_i = 0; sel_i = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic classic(input bit we, input logic [15:0] adr, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] cti, output logic [31:0] r);
      int w;
      w = adr >> 2;
      cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = d; sel_i = s; cti_i = cti;
      @(negedge clk); chk("cl_ack_first", ack_o, 0);
      step();
      @(negedge clk); chk("cl_ack", ack_o, 1); chk("cl_dat", dat_o, mdl[w]); r = dat_o;
      step();
      if (we) mdl_write(w, d, s);
      @(negedge clk); chk("cl_gap", ack_o, 0);
      bus_idle();
      step();
   endtask

   task automatic burst(input logic [15:0] adr0, input logic [2:0] mode, input logic [1:0] bte,
                        input int nb, input bit we, input logic [3:0] s,
                        input int wait_beat, input int wait_len,
                        input logic [31:0] wd [16], output logic [31:0] rd [16]);
      int w;
      w = adr0 >> 2;
      for (int i = 0; i < 16; i++) rd[i] = '0;
      cyc_i = 1; stb_i = 1; we_i = we; sel_i = s; bte_i = bte;
      adr_i = 16'(w << 2); dat_i = wd[0]; cti_i = (nb == 1) ? 3'b111 : mode;
      @(negedge clk); chk("bu_ack_first", ack_o, 0);
      step();
      for (int k = 0; k < nb; k++) begin
         if (k > 0 && k == wait_beat && wait_len > 0) begin
            stb_i = 0;
            for (int j = 0; j < wait_len; j++) begin
               @(negedge clk);
               chk("bu_wait_ack", ack_o, 0);
               chk("bu_wait_dat", dat_o, mdl[w]);
               step();
            end
            stb_i = 1;
         end
         @(negedge clk); chk("bu_ack", ack_o, 1); chk("bu_dat", dat_o, mdl[w]); rd[k] = dat_o;
         step();
         if (we) mdl_write(w, wd[k], s);
         if (mode == 3'b010) w = nxt(w, bte);
         adr_i = 16'(w << 2);
         dat_i = (k + 1 < 16) ? wd[k+1] : '0;
         cti_i = (k + 1 == nb - 1) ? 3'b111 : (k + 1 >= nb ? 3'b000 : mode);
      end
      @(negedge clk); chk("bu_end_ack", ack_o, 0);
      bus_idle();
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [8];
      logic [31:0] wd [16], rd [16], r;
      int          nb, wb, wl;
      logic [2:0]  mode;

      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

      tbl[0] = '{1, 16'h0010, 32'hDEADBEEF, 4'b1111, 32'h00000000};
      tbl[1] = '{0, 16'h0010, 32'h0,        4'b1111, 32'hDEADBEEF};
      tbl[2] = '{1, 16'h0010, 32'h000000AA, 4'b0001, 32'hDEADBEEF};
      tbl[3] = '{0, 16'h0010, 32'h0,        4'b1111, 32'hDEADBEAA};
      tbl[4] = '{1, 16'h0014, 32'h11223344, 4'b1100, 32'h00000000};
      tbl[5] = '{0, 16'h0014, 32'h0,        4'b1111, 32'h11220000};
      tbl[6] = '{1, 16'h0013, 32'h55667788, 4'b0010, 32'hDEADBEAA};
      tbl[7] = '{0, 16'h0010, 32'h0,        4'b1111, 32'hDEAD77AA};

      // reset with the bus active
      cyc_i = 1; stb_i = 1;
      step(); step();
      @(negedge clk);
      chk("rst_ack", ack_o, 0); chk("rst_dat", dat_o, 0); chk("rst_err", err_o, 0);
      rst = 0; bus_idle();
      step();

      for (int i = 0; i < 8; i++) begin
         classic(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, 3'b000, r);
         chk($sformatf("tbl%0d", i), r, tbl[i].exp);
      end

      // preload words 0x20..0x2F with their index
      for (int i = 0; i < 16; i++) wd[i] = 32'h20 + i;
      burst(16'h0080, 3'b010, 2'b00, 16, 1, 4'hF, 0, 0, wd, rd);
      burst(16'h0080, 3'b010, 2'b00, 4, 0, 4'hF, 0, 0, wd, rd);
      for (int i = 0; i < 4; i++) chk($sformatf("lin%0d", i), rd[i], 32'h20 + i);
      burst(16'h008C, 3'b010, 2'b01, 4, 0, 4'hF, 0, 0, wd, rd);
      chk("wrap4_0", rd[0], 32'h23); chk("wrap4_1", rd[1], 32'h20);
      chk("wrap4_2", rd[2], 32'h21); chk("wrap4_3", rd[3], 32'h22);
      burst(16'h0094, 3'b010, 2'b10, 4, 0, 4'hF, 0, 0, wd, rd);
      chk("wrap8_2", rd[2], 32'h27); chk("wrap8_3", rd[3], 32'h20);
      burst(16'h00B8, 3'b010, 2'b11, 3, 0, 4'hF, 0, 0, wd, rd);
      chk("wrap16_2", rd[2], 32'h20);

      // top-word write burst wraps to word 0, with a 2-clock master wait
      wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
      burst(16'hFFFC, 3'b010, 2'b00, 2, 1, 4'hF, 1, 2, wd, rd);
      classic(0, 16'hFFFC, 0, 4'hF, 3'b000, r); chk("top_w", r, 32'hCAFE0001);
      classic(0, 16'h0000, 0, 4'hF, 3'b000, r); chk("wrap_w0", r, 32'hCAFE0002);

      // constant-address write burst returns freshly written data
      wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
      burst(16'h0300, 3'b001, 2'b00, 3, 1, 4'hF, 0, 0, wd, rd);
      chk("const_wf1", rd[1], 32'h1); chk("const_wf2", rd[2], 32'h2);

      // cyc_i dropped with beat 1 pending
      cyc_i = 1; stb_i = 1; we_i = 1; sel_i = 4'hF; cti_i = 3'b010; adr_i = 16'h0400; dat_i = 32'hA0A0A0A0;
      step();
      @(negedge clk); chk("cyc_b0_ack", ack_o, 1);
      step(); mdl_write(16'h100, 32'hA0A0A0A0, 4'hF);
      adr_i = 16'h0404; dat_i = 32'hB0B0B0B0; cyc_i = 0;
      @(negedge clk); chk("cyc_drop_ack", ack_o, 0);
      step();
      cyc_i = 1; we_i = 0; cti_i = 3'b000;
      @(negedge clk); chk("cyc_drop_ackreg", ack_o, 0);
      bus_idle(); step();
      classic(0, 16'h0400, 0, 4'hF, 3'b000, r); chk("cyc_b0", r, 32'hA0A0A0A0);
      classic(0, 16'h0404, 0, 4'hF, 3'b000, r); chk("cyc_b1_nowrite", r, 32'h0);

      // rst asserted with beat 1 pending
      cyc_i = 1; stb_i = 1; we_i = 1; sel_i = 4'hF; cti_i = 3'b010; adr_i = 16'h0440; dat_i = 32'hC1C1C1C1;
      step();
      @(negedge clk); chk("rst_b0_ack", ack_o, 1);
      step(); mdl_write(16'h110, 32'hC1C1C1C1, 4'hF);
      adr_i = 16'h0444; dat_i = 32'hD2D2D2D2; rst = 1;
      step();
      rst = 0;
      @(negedge clk); chk("rst_mid_ack", ack_o, 0); chk("rst_mid_dat", dat_o, 0);
      bus_idle(); step();
      classic(0, 16'h0440, 0, 4'hF, 3'b000, r); chk("rst_b0", r, 32'hC1C1C1C1);
      classic(0, 16'h0444, 0, 4'hF, 3'b000, r); chk("rst_b1_nowrite", r, 32'h0);

`ifdef WB_RAM_BURST_ERR_EN
      cyc_i = 1; stb_i = 1; we_i = 1; sel_i = 4'hF; cti_i = 3'b011; adr_i = 16'h0800; dat_i = 32'hFFFFFFFF;
      @(negedge clk); chk("err_pre", err_o, 0);
      step();
      @(negedge clk); chk("err_hi", err_o, 1); chk("err_noack", ack_o, 0);
      step();
      @(negedge clk); chk("err_one", err_o, 0); chk("err_noack2", ack_o, 0);
      bus_idle(); step();
      classic(0, 16'h0800, 0, 4'hF, 3'b000, r); chk("err_nowrite", r, 32'h0);
`else
      classic(1, 16'h0800, 32'h600DF00D, 4'hF, 3'b011, r);
      classic(0, 16'h0800, 0, 4'hF, 3'b110, r); chk("rsvd_classic", r, 32'h600DF00D);
      chk("rsvd_err", err_o, 0);
`endif

      // randomized traffic in a small window so reads hit earlier writes
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < 16; i++) wd[i] = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            classic(1'($urandom_range(0, 1)), 16'((16'h1000 + $urandom_range(0, 255) * 4) | $urandom_range(0, 3)),
                    wd[0], 4'($urandom), $urandom_range(0, 1) ? 3'b111 : 3'b000, r);
         end else begin
            nb   = $urandom_range(1, 8);
            wb   = $urandom_range(1, 8);
            wl   = $urandom_range(0, 2);
            mode = $urandom_range(0, 3) == 0 ? 3'b001 : 3'b010;
            burst(16'(16'h1000 + $urandom_range(0, 255) * 4), mode, 2'($urandom), nb,
                  1'($urandom_range(0, 1)), 4'($urandom), wb, wl, wd, rd);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_ram_burst.md
Name: wb_ram_burst

Overview:
- Single-port Wishbone B4 RAM slave with registered-feedback burst support: Cycle Type Identifier (CTI) and Burst Type Extension (BTE).
- Classic cycles take 2 clocks per beat; incrementing bursts sustain 1 beat/clock after a 1-clock initial latency, using internal next-address prediction.
- Sits on a Wishbone interconnect as a general scratch/program memory for burst-capable masters.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8/16/32/64).
- ADDR_WIDTH, 16, byte address width.
- SELECT_WIDTH, 4, byte-lane select width (DATA_WIDTH/8).
- Derived: WORD_ADDR_WIDTH = ADDR_WIDTH - clog2(SELECT_WIDTH); depth = 2**WORD_ADDR_WIDTH words. Low clog2(SELECT_WIDTH) address bits are ignored.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- adr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data.
- we_i  in  1  write enable.
- sel_i  in  SELECT_WIDTH  byte-lane select.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- cti_i  in  3  cycle type: 000 classic, 001 constant-address burst, 010 incrementing burst, 111 end-of-burst.
- bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- ack_o  out  1  acknowledge.
- err_o  out  1  error; present only with the optional feature, else tied 0.

Behaviour:
- Reset: ack_reg=0, dat_o=0, err_o=0, state=IDLE, wrap/addr registers cleared. Memory is not cleared by rst; it is zero-initialised at time 0 only.
- ack_o = ack_reg & cyc_i & stb_i (combinational gating). A beat completes at an edge where cyc_i & stb_i & ack_o.
- Writes commit only at a completion edge: mem[adr_i word] updated per byte lane where sel_i is 1. Unselected lanes are unchanged. Each beat writes exactly once.
- IDLE, edge with cyc_i & stb_i & ~ack_reg: dat_o <= mem[adr_i]; ack_reg <= 1.
  - If cti_i is 001 or 010 -> go to BURST.
  - Otherwise -> go to CLASSIC.
- CLASSIC, at completion edge: ack_reg <= 0 -> IDLE. This gives one idle clock between beats (2 clk/beat).
- BURST, at completion edge:
  - cti_i=010: next = incremented word address. dat_o <= mem[next]; ack_reg stays 1.
  - cti_i=001: dat_o <= mem[adr_i], re-read after the write so written data is returned; ack_reg stays 1.
  - cti_i=111 or 000: ack_reg <= 0 -> IDLE.
- Address increment rule: linear = word address + 1, modulo depth (wraps from depth-1 to 0). Wrap-N increments the low log2(N) word-address bits modulo N; upper bits are held.
- Read of a just-written predicted address in the same edge: the write takes precedence, so dat_o shows the new data (write-first).
- stb_i low mid-burst (master wait state): no completion, state/ack_reg/dat_o held. When stb_i returns, the same beat is presented again.
- cyc_i low in any state: next edge forces ack_reg=0 -> IDLE. Any pending beat is abandoned with no write.
- rst asserted mid-burst: next edge returns to reset values; the in-flight beat is not written.

Optional Feature:
- Macro: WB_RAM_BURST_ERR_EN.
- Defined: err_o port exists. A start edge with cti_i in 011..110 (reserved) asserts err_reg instead of ack_reg for one beat, then returns to IDLE with no memory access. err_o = err_reg & cyc_i & stb_i. Reset value 0.
- Undefined: err_o is tied 0, and reserved CTI values are treated as classic (000).

Test Plan:
- Classic write 0xDEADBEEF to 0x0010 with sel=1111, then classic read of 0x0010 -> ack_o high 1 clk after each stb; read returns 0xDEADBEEF; 2 clk/beat.
- Byte write 0x000000AA to 0x0010 with sel=0001, then read -> 0xDEADBEAA.
- Preload words 0x20..0x2F = index; linear incrementing read burst at 0x0080, 4 beats, last beat cti=111 -> ack_o high 4 consecutive clks; data 0x20, 0x21, 0x22, 0x23; ack_o low next clk.
- Wrap-4 read burst starting at 0x008C, 4 beats -> data words 0x23, 0x20, 0x21, 0x22.
- Incrementing write burst at the top word (depth-1), 2 beats, then reads -> second beat lands at word 0 (linear wrap); stb_i dropped 2 clks mid-burst -> no extra beats, no duplicate writes.
- cyc_i dropped mid-burst, and separately rst asserted mid-burst -> ack_o low next clk, no write of the pending beat. With WB_RAM_BURST_ERR_EN defined, cti=011 start -> err_o high 1 clk, ack_o 0, memory unchanged.
